// File: rtl/alu_op_sequencer.sv
// Sequencer for a combinational ALU: latches one operand pair and sweeps ALU_Sel from 0 to Sel_Last.
// Each result is presented on a valid/ready channel. Define ALU_SEQ_CHKSUM_EN to add the Chk_Sum output.
module alu_op_sequencer #(
  parameter int DATA_WID   = 4,
  parameter int SEL_WID    = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Start,
  input  logic                Abort,
  input  logic [DATA_WID-1:0] A_In,
  input  logic [DATA_WID-1:0] B_In,
  input  logic [SEL_WID-1:0]  Sel_Last,
  output logic [DATA_WID-1:0] A,
  output logic [DATA_WID-1:0] B,
  output logic [SEL_WID-1:0]  ALU_Sel,
  input  logic [DATA_WID-1:0] ALU_Output,
  output logic                Res_Valid,
  input  logic                Res_Ready,
  output logic [DATA_WID-1:0] Res_Data,
  output logic [SEL_WID-1:0]  Res_Sel,
  output logic                Res_Last,
`ifdef ALU_SEQ_CHKSUM_EN
  output logic [DATA_WID-1:0] Chk_Sum,
`endif
  output logic                Busy,
  output logic                Done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYC - 1);

  state_t              state_q, state_d;
  logic [DATA_WID-1:0] a_q, a_d, b_q, b_d;
  logic [SEL_WID-1:0]  sel_q, sel_d, sel_last_q, sel_last_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_WID-1:0] res_data_q, res_data_d;
  logic [SEL_WID-1:0]  res_sel_q, res_sel_d;
  logic                res_last_q, res_last_d;
  logic [DATA_WID-1:0] chk_q, chk_d;
  logic                handshake;

  assign handshake = res_valid_q && Res_Ready;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    sel_last_d  = sel_last_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_sel_d   = res_sel_q;
    res_last_d  = res_last_q;
    chk_d       = chk_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          a_d        = A_In;
          b_d        = B_In;
          sel_last_d = Sel_Last;
          sel_d      = '0;
          cnt_d      = CNT_RELOAD;
          chk_d      = '0;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (Abort) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (cnt_q == 4'd0) begin
          res_data_d  = ALU_Output;
          res_sel_d   = sel_q;
          res_last_d  = (sel_q == sel_last_q);
          res_valid_d = 1'b1;
          state_d     = PRESENT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      PRESENT: begin
        // A handshake coinciding with Abort is still consumed (and folded into the checksum).
        if (handshake) begin
          res_valid_d = 1'b0;
          chk_d       = chk_q ^ res_data_q;
          if (Abort) begin
            state_d = IDLE;
          end else if (res_last_q) begin
            state_d = DONE;
          end else begin
            sel_d   = sel_q + 1'b1;
            cnt_d   = CNT_RELOAD;
            state_d = SETTLE;
          end
        end else if (Abort) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      sel_last_q  <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_sel_q   <= '0;
      res_last_q  <= 1'b0;
      chk_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      sel_last_q  <= sel_last_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_sel_q   <= res_sel_d;
      res_last_q  <= res_last_d;
      chk_q       <= chk_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign ALU_Sel   = sel_q;
  assign Res_Valid = res_valid_q;
  assign Res_Data  = res_data_q;
  assign Res_Sel   = res_sel_q;
  assign Res_Last  = res_last_q;
  assign Busy      = (state_q != IDLE);
  assign Done      = (state_q == DONE);
`ifdef ALU_SEQ_CHKSUM_EN
  assign Chk_Sum   = chk_q;
`else
  logic unused_chk;
  assign unused_chk = ^chk_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with an adder ALU stub (A+B+ALU_Sel mod 16).
// Two instances: SETTLE_CYC=1 for the main sweeps, SETTLE_CYC=3 for the latency case.
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start, abort, res_ready;
  logic [3:0] a_in, b_in, sel_last_in;
  logic [3:0] a, b, alu_sel, alu_out, res_data, res_sel;
  logic       res_valid, res_last, busy, done;
`ifdef ALU_SEQ_CHKSUM_EN
  logic [3:0] chk_sum, chk_sum3;
`endif

  logic       start3;
  logic [3:0] a3, b3, alu_sel3, alu_out3, res_data3, res_sel3;
  logic       res_valid3, res_last3, busy3, done3;

  assign alu_out  = a + b + alu_sel;
  assign alu_out3 = a3 + b3 + alu_sel3;

  int checks = 0;
  int passes = 0;

  alu_op_sequencer #(.DATA_WID(4), .SEL_WID(4), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .Start(start), .Abort(abort),
    .A_In(a_in), .B_In(b_in), .Sel_Last(sel_last_in),
    .A(a), .B(b), .ALU_Sel(alu_sel), .ALU_Output(alu_out),
    .Res_Valid(res_valid), .Res_Ready(res_ready), .Res_Data(res_data),
    .Res_Sel(res_sel), .Res_Last(res_last),
`ifdef ALU_SEQ_CHKSUM_EN
    .Chk_Sum(chk_sum),
`endif
    .Busy(busy), .Done(done)
  );

  alu_op_sequencer #(.DATA_WID(4), .SEL_WID(4), .SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .Start(start3), .Abort(1'b0),
    .A_In(4'd3), .B_In(4'd5), .Sel_Last(4'd1),
    .A(a3), .B(b3), .ALU_Sel(alu_sel3), .ALU_Output(alu_out3),
    .Res_Valid(res_valid3), .Res_Ready(1'b1), .Res_Data(res_data3),
    .Res_Sel(res_sel3), .Res_Last(res_last3),
`ifdef ALU_SEQ_CHKSUM_EN
    .Chk_Sum(chk_sum3),
`endif
    .Busy(busy3), .Done(done3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input logic [3:0] ai, input logic [3:0] bi, input logic [3:0] sl);
    a_in = ai; b_in = bi; sel_last_in = sl; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    start = 0; abort = 0; res_ready = 1; a_in = 0; b_in = 0; sel_last_in = 0; start3 = 0;

    // Reset values
    #12;
    check("rst_A", a, 0);
    check("rst_ALU_Sel", alu_sel, 0);
    check("rst_Res_Valid", res_valid, 0);
    check("rst_Busy", busy, 0);
    check("rst_Done", done, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Full sweep, ready high; Start re-pulsed with A_In=7 mid-sweep
    start_sweep(4'd3, 4'd5, 4'd15);
    check("t1_busy", busy, 1);
    check("t1_A", a, 3);
    check("t1_valid0", res_valid, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      $display("t1 result sel=%0d data=%0d last=%0b", res_sel, res_data, res_last);
      check("t1_valid", res_valid, 1);
      check("t1_data", res_data, 32'((8 + i) % 16));
      check("t1_sel", res_sel, i);
      check("t1_last", res_last, (i == 15) ? 1 : 0);
      if (i == 3) begin a_in = 4'd7; start = 1'b1; end
      tick();
      start = 1'b0;
      check("t1_valid_low", res_valid, 0);
      if (i == 3) check("t1_A_kept", a, 3);
      if (i < 15) check("t1_done_low", done, 0);
    end
    check("t1_done", done, 1);
    check("t1_busy_done", busy, 1);
`ifdef ALU_SEQ_CHKSUM_EN
    check("t1_chk", chk_sum, 0);
`endif
    tick();
    check("t1_done_end", done, 0);
    check("t1_idle", busy, 0);

    // Backpressure at sel 4, then Abort together with handshake at sel 6
    start_sweep(4'd3, 4'd5, 4'd15);
    for (int i = 0; i < 7; i++) begin
      if (i == 4) res_ready = 1'b0;
      tick();
      $display("t2 result sel=%0d data=%0d", res_sel, res_data);
      check("t2_data", res_data, 32'((8 + i) % 16));
      check("t2_sel", res_sel, i);
      if (i == 4) begin
        for (int k = 0; k < 4; k++) begin
          tick();
          check("t2_hold_valid", res_valid, 1);
          check("t2_hold_data", res_data, 12);
          check("t2_hold_sel", res_sel, 4);
          check("t2_hold_alusel", alu_sel, 4);
        end
        res_ready = 1'b1;
      end
      if (i == 6) abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t2_valid_low", res_valid, 0);
    end
    check("t2_abort_busy", busy, 0);
    check("t2_abort_done", done, 0);
    check("t2_abort_A", a, 3);
    check("t2_abort_alusel", alu_sel, 6);
    tick();
    check("t2_no_done", done, 0);

    // Sel_Last=0: one result then Done
    start_sweep(4'd15, 4'd1, 4'd0);
    tick();
    $display("t3 result sel=%0d data=%0d last=%0b", res_sel, res_data, res_last);
    check("t3_valid", res_valid, 1);
    check("t3_data", res_data, 0);
    check("t3_sel", res_sel, 0);
    check("t3_last", res_last, 1);
    tick();
    check("t3_done", done, 1);
`ifdef ALU_SEQ_CHKSUM_EN
    check("t3_chk", chk_sum, 0);
`endif
    tick();
    check("t3_idle", busy, 0);

    // Async reset in SETTLE at sel 9
    start_sweep(4'd3, 4'd5, 4'd15);
    for (int i = 0; i < 9; i++) begin
      tick();
      tick();
    end
    check("t4_pre_alusel", alu_sel, 9);
    check("t4_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    $display("t4 async reset: A=%0d ALU_Sel=%0d busy=%0b", a, alu_sel, busy);
    check("t4_rst_A", a, 0);
    check("t4_rst_B", b, 0);
    check("t4_rst_alusel", alu_sel, 0);
    check("t4_rst_busy", busy, 0);
    check("t4_rst_sel", res_sel, 0);
    check("t4_rst_data", res_data, 0);
    tick();
    rst_n = 1'b1;
    start_sweep(4'd3, 4'd5, 4'd15);
    check("t4_restart_alusel", alu_sel, 0);
    check("t4_restart_A", a, 3);
    tick();
    check("t4_restart_sel", res_sel, 0);
    check("t4_restart_data", res_data, 8);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_idle", busy, 0);

    // SETTLE_CYC=3 instance
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    tick();
    check("t5_valid_e1", res_valid3, 0);
    tick();
    check("t5_valid_e2", res_valid3, 0);
    tick();
    $display("t5 result sel=%0d data=%0d last=%0b", res_sel3, res_data3, res_last3);
    check("t5_valid_e3", res_valid3, 1);
    check("t5_data0", res_data3, 8);
    check("t5_last0", res_last3, 0);
    tick(); tick(); tick();
    check("t5_valid_gap", res_valid3, 0);
    tick();
    $display("t5 result sel=%0d data=%0d last=%0b", res_sel3, res_data3, res_last3);
    check("t5_data1", res_data3, 9);
    check("t5_sel1", res_sel3, 1);
    check("t5_last1", res_last3, 1);
    tick();
    check("t5_done", done3, 1);
    tick();
    check("t5_done_end", done3, 0);
    check("t5_idle", busy3, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
